// File: rtl/mmu_request_arbiter.sv
// Arbitrates the shared MMU between the code-fetch and data requesters, sequences
// the start/ready handshake and returns the physical address with a one-cycle done.
module mmu_request_arbiter #(
   parameter int CS_INDEX       = 1,
   parameter int STARVE_LIMIT   = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_fetch_request,
   input  logic [31:0] i_fetch_effective_address,
   output logic        o_fetch_done,
   input  logic        i_data_request,
   input  logic [2:0]  i_data_segment_index,
   input  logic [31:0] i_data_effective_address,
   input  logic        i_data_write_enable,
   output logic        o_data_done,
   output logic [31:0] o_physical_address,
   output logic        o_fault,
   output logic        o_busy,
   output logic        o_mmu_vaild,
   input  logic        i_mmu_ready,
   output logic [2:0]  o_mmu_segment_index,
   output logic [31:0] o_mmu_effective_address,
   output logic        o_mmu_write_enable,
   input  logic [31:0] i_mmu_physical_address
);

   localparam logic [2:0] CS_SEGMENT = 3'(CS_INDEX);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT} state_t;

   state_t      state;
   logic        owner;
   logic [3:0]  starve_count;
   logic [7:0]  timer;
   logic        fetch_eligible;
   logic        data_eligible;
   logic        grant_fetch;
   logic        grant_data;

   // A requester whose done is still high is holding a request that was just served.
   assign fetch_eligible = i_fetch_request & ~o_fetch_done;
   assign data_eligible  = i_data_request & ~o_data_done;
   assign grant_fetch    = fetch_eligible & (~data_eligible | (starve_count == STARVE_MAX));
   assign grant_data     = data_eligible & ~grant_fetch;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                   <= IDLE;
         owner                   <= 1'b0;
         starve_count            <= '0;
         timer                   <= '0;
         o_fetch_done            <= 1'b0;
         o_data_done             <= 1'b0;
         o_physical_address      <= '0;
         o_fault                 <= 1'b0;
         o_busy                  <= 1'b0;
         o_mmu_vaild             <= 1'b0;
         o_mmu_segment_index     <= '0;
         o_mmu_effective_address <= '0;
         o_mmu_write_enable      <= 1'b0;
      end else begin
         o_fetch_done <= 1'b0;
         o_data_done  <= 1'b0;
         o_fault      <= 1'b0;
         o_mmu_vaild  <= 1'b0;
         case (state)
            IDLE: begin
               if (!i_fetch_request) begin
                  starve_count <= '0;
               end
               if (grant_fetch) begin
                  owner                   <= 1'b0;
                  starve_count            <= '0;
                  o_mmu_segment_index     <= CS_SEGMENT;
                  o_mmu_effective_address <= i_fetch_effective_address;
                  o_mmu_write_enable      <= 1'b0;
                  o_mmu_vaild             <= 1'b1;
                  o_busy                  <= 1'b1;
                  state                   <= ISSUE;
               end else if (grant_data) begin
                  owner                   <= 1'b1;
                  if (fetch_eligible && (starve_count != STARVE_MAX)) begin
                     starve_count <= starve_count + 4'd1;
                  end
                  o_mmu_segment_index     <= i_data_segment_index;
                  o_mmu_effective_address <= i_data_effective_address;
                  o_mmu_write_enable      <= i_data_write_enable;
                  o_mmu_vaild             <= 1'b1;
                  o_busy                  <= 1'b1;
                  state                   <= ISSUE;
               end
            end
            ISSUE: begin
               state <= DRAIN;
            end
            // The MMU still presents the ready from its previous access here.
            DRAIN: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (i_mmu_ready) begin
                  o_physical_address <= i_mmu_physical_address;
                  o_fetch_done       <= ~owner;
                  o_data_done        <= owner;
                  o_busy             <= 1'b0;
                  state              <= IDLE;
               end else if (timer == TIMER_LAST) begin
                  o_fault      <= 1'b1;
                  o_fetch_done <= ~owner;
                  o_data_done  <= owner;
                  o_busy       <= 1'b0;
                  state        <= IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// Randomized scoreboard bench for mmu_request_arbiter with a behavioural MMU and
// a rule-level arbitration model predicting grant order and completion results.
module tb_mmu_request_arbiter;

   localparam int CS_INDEX       = 1;
   localparam int STARVE_LIMIT   = 3;
   localparam int TIMEOUT_CYCLES = 64;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_fetch_request = 1'b0;
   logic [31:0] i_fetch_effective_address = '0;
   logic        o_fetch_done;
   logic        i_data_request = 1'b0;
   logic [2:0]  i_data_segment_index = '0;
   logic [31:0] i_data_effective_address = '0;
   logic        i_data_write_enable = 1'b0;
   logic        o_data_done;
   logic [31:0] o_physical_address;
   logic        o_fault;
   logic        o_busy;
   logic        o_mmu_vaild;
   logic        i_mmu_ready = 1'b1;
   logic [2:0]  o_mmu_segment_index;
   logic [31:0] o_mmu_effective_address;
   logic        o_mmu_write_enable;
   logic [31:0] i_mmu_physical_address = '0;

   mmu_request_arbiter #(
      .CS_INDEX       (CS_INDEX),
      .STARVE_LIMIT   (STARVE_LIMIT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clock                     (clock),
      .reset_n                   (reset_n),
      .i_fetch_request           (i_fetch_request),
      .i_fetch_effective_address (i_fetch_effective_address),
      .o_fetch_done              (o_fetch_done),
      .i_data_request            (i_data_request),
      .i_data_segment_index      (i_data_segment_index),
      .i_data_effective_address  (i_data_effective_address),
      .i_data_write_enable       (i_data_write_enable),
      .o_data_done               (o_data_done),
      .o_physical_address        (o_physical_address),
      .o_fault                   (o_fault),
      .o_busy                    (o_busy),
      .o_mmu_vaild               (o_mmu_vaild),
      .i_mmu_ready               (i_mmu_ready),
      .o_mmu_segment_index       (o_mmu_segment_index),
      .o_mmu_effective_address   (o_mmu_effective_address),
      .o_mmu_write_enable        (o_mmu_write_enable),
      .i_mmu_physical_address    (i_mmu_physical_address)
   );

   always #5 clock = ~clock;

   // delay: 0 = paging off, >0 = ready after that many cycles, <0 = ready never returns
   typedef struct {
      logic        owner;
      logic [2:0]  seg;
      logic [31:0] ea;
      logic        we;
      int          delay;
      logic [31:0] pa;
      logic        fault;
   } txn_t;

   txn_t        op_q[$];
   txn_t        done_q[$];
   int          errors = 0;
   int          checks = 0;
   int          done_count = 0;
   int          cycle = 0;
   int          starve_model = 0;
   logic [31:0] model_pa = '0;
   logic        mmu_release = 1'b0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic report_unexpected(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: event seen with nothing expected (cycle %0d)", name, cycle);
   endtask

   function automatic logic [31:0] mmu_result(input logic [2:0] seg, input logic [31:0] ea, input int delay);
      logic [31:0] base;
      base = {9'd0, seg, 20'd0};
      if (delay == 0) return base + ea;
      return (ea ^ 32'h5A00_0000) + base + 32'h0000_0100;
   endfunction

   task automatic push_txn(input logic owner, input logic [2:0] seg, input logic [31:0] ea,
                           input logic we, input int delay);
      txn_t t;
      t.owner = owner;
      t.seg   = seg;
      t.ea    = ea;
      t.we    = we;
      t.delay = delay;
      if (delay < 0) begin
         t.fault = 1'b1;
         t.pa    = model_pa;
      end else begin
         t.fault  = 1'b0;
         t.pa     = mmu_result(seg, ea, delay);
         model_pa = t.pa;
      end
      op_q.push_back(t);
      done_q.push_back(t);
   endtask

   // Behavioural MMU: ready stays stale-high through the drain cycle, then follows the delay.
   txn_t mmu_cur;
   int   mmu_phase = 0;
   int   mmu_cnt = 0;
   logic mmu_unstable = 1'b0;

   always @(negedge clock) begin
      if (!reset_n) begin
         mmu_phase   = 0;
         i_mmu_ready = 1'b1;
      end else begin
         if (mmu_phase != 0 &&
             (o_mmu_segment_index !== mmu_cur.seg || o_mmu_effective_address !== mmu_cur.ea ||
              o_mmu_write_enable !== mmu_cur.we))
            mmu_unstable = 1'b1;
         case (mmu_phase)
            0: if (o_mmu_vaild) begin
               if (op_q.size() == 0) begin
                  report_unexpected("unexpected_issue");
               end else begin
                  mmu_cur = op_q.pop_front();
                  check_output("mmu_segment", 64'(o_mmu_segment_index), 64'(mmu_cur.seg));
                  check_output("mmu_address", 64'(o_mmu_effective_address), 64'(mmu_cur.ea));
                  check_output("mmu_write", 64'(o_mmu_write_enable), 64'(mmu_cur.we));
                  mmu_unstable = 1'b0;
                  if (mmu_cur.delay == 0) i_mmu_physical_address = mmu_cur.pa;
                  mmu_phase = 1;
               end
            end
            1: begin
               check_output("vaild_pulse_width", 64'(o_mmu_vaild), 64'd0);
               if (mmu_cur.delay == 0) begin
                  check_output("operands_stable", 64'(mmu_unstable), 64'd0);
                  mmu_phase = 0;
               end else begin
                  mmu_phase = 2;
               end
            end
            2: begin
               i_mmu_ready = 1'b0;
               i_mmu_physical_address = 32'hDEAD_BEEF;
               mmu_cnt = mmu_cur.delay;
               mmu_phase = 3;
            end
            default: begin
               if (mmu_cur.delay < 0) begin
                  if (mmu_release) begin
                     i_mmu_ready = 1'b1;
                     mmu_phase = 0;
                  end
               end else begin
                  mmu_cnt--;
                  if (mmu_cnt == 0) begin
                     check_output("operands_stable", 64'(mmu_unstable), 64'd0);
                     i_mmu_physical_address = mmu_cur.pa;
                     i_mmu_ready = 1'b1;
                     mmu_phase = 0;
                  end
               end
            end
         endcase
      end
   end

   // Completion monitor, independent of whichever task issued the request.
   always @(negedge clock) begin
      txn_t t;
      if (reset_n && (o_fetch_done || o_data_done)) begin
         if (done_q.size() == 0) begin
            report_unexpected("unexpected_done");
         end else begin
            t = done_q.pop_front();
            check_output("done_owner", 64'({o_fetch_done, o_data_done}), t.owner ? 64'd1 : 64'd2);
            check_output("physical_address", 64'(o_physical_address), 64'(t.pa));
            check_output("fault", 64'(o_fault), 64'(t.fault));
         end
         done_count++;
      end
   end

   task automatic apply_stimulus(input bit do_fetch, input bit do_data, input logic [2:0] dseg,
                                 input logic [31:0] dea, input logic dwe, input logic [31:0] fea,
                                 input int delay, input bit hold_extra, output int latency);
      bit fwait, dwait, fdrop;
      int start, waited;
      if (do_fetch && (!do_data || starve_model == STARVE_LIMIT)) begin
         push_txn(1'b0, 3'(CS_INDEX), fea, 1'b0, delay);
         starve_model = 0;
         if (do_data) push_txn(1'b1, dseg, dea, dwe, delay);
      end else if (do_data) begin
         push_txn(1'b1, dseg, dea, dwe, delay);
         if (do_fetch) begin
            if (starve_model < STARVE_LIMIT) starve_model++;
            push_txn(1'b0, 3'(CS_INDEX), fea, 1'b0, delay);
            starve_model = 0;
         end else begin
            starve_model = 0;
         end
      end
      @(negedge clock); #1;
      start   = cycle;
      latency = -1;
      i_fetch_effective_address = fea;
      i_data_segment_index      = dseg;
      i_data_effective_address  = dea;
      i_data_write_enable       = dwe;
      i_fetch_request = do_fetch;
      i_data_request  = do_data;
      fwait  = do_fetch;
      dwait  = do_data;
      fdrop  = 1'b0;
      waited = 0;
      while ((fwait || dwait || fdrop) && waited < 200) begin
         @(negedge clock); #1;
         waited++;
         if (!(do_fetch && do_data) && waited == 2) begin
            i_fetch_effective_address = $urandom;
            i_data_effective_address  = $urandom;
            i_data_segment_index      = 3'($urandom_range(0, 5));
            i_data_write_enable       = ~dwe;
         end
         if (fdrop) begin
            i_fetch_request = 1'b0;
            fdrop = 1'b0;
         end
         if (fwait && o_fetch_done) begin
            fwait = 1'b0;
            if (latency < 0) latency = cycle - start;
            if (hold_extra) fdrop = 1'b1;
            else i_fetch_request = 1'b0;
         end
         if (dwait && o_data_done) begin
            dwait = 1'b0;
            if (latency < 0) latency = cycle - start;
            i_data_request = 1'b0;
         end
      end
      if (fwait || dwait) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: fetch_pending=%0d data_pending=%0d after %0d cycles, required completion",
                  fwait, dwait, waited);
         i_fetch_request = 1'b0;
         i_data_request  = 1'b0;
      end
   endtask

   // Both requesters held for n accesses; a just-served requester is ineligible, so the other wins.
   task automatic run_held(input int n);
      logic last_owner;
      logic win;
      int   target, waited;
      for (int i = 0; i < n; i++) begin
         if (i == 0) win = (starve_model == STARVE_LIMIT) ? 1'b0 : 1'b1;
         else win = ~last_owner;
         if (win) begin
            if (starve_model < STARVE_LIMIT) starve_model++;
            push_txn(1'b1, 3'd2, 32'h0000_4000, 1'b0, 0);
         end else begin
            starve_model = 0;
            push_txn(1'b0, 3'(CS_INDEX), 32'h0000_8000, 1'b0, 0);
         end
         last_owner = win;
      end
      @(negedge clock); #1;
      target = done_count + n;
      i_fetch_effective_address = 32'h0000_8000;
      i_data_segment_index      = 3'd2;
      i_data_effective_address  = 32'h0000_4000;
      i_data_write_enable       = 1'b0;
      i_fetch_request = 1'b1;
      i_data_request  = 1'b1;
      waited = 0;
      while (done_count < target && waited < 400) begin
         @(negedge clock); #1;
         waited++;
      end
      i_fetch_request = 1'b0;
      i_data_request  = 1'b0;
      check_output("held_done_count", 64'(done_count), 64'(target));
   endtask

   initial begin
      int lat;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_output("reset_control", 64'({o_fetch_done, o_data_done, o_fault, o_busy, o_mmu_vaild, o_mmu_write_enable}), 64'd0);
      check_output("reset_physical_address", 64'(o_physical_address), 64'd0);
      check_output("reset_mmu_operands", 64'({o_mmu_segment_index, o_mmu_effective_address}), 64'd0);
      reset_n = 1'b1;

      apply_stimulus(1'b0, 1'b1, 3'd3, 32'h0000_1234, 1'b1, 32'h0, 0, 1'b0, lat);
      check_output("data_latency", 64'(lat), 64'd4);

      apply_stimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0000_FFF0, 0, 1'b1, lat);
      check_output("fetch_latency", 64'(lat), 64'd4);
      repeat (4) @(negedge clock);
      #1;
      check_output("no_regrant_busy", 64'(o_busy), 64'd0);

      run_held(8);

      apply_stimulus(1'b0, 1'b1, 3'd5, 32'h0001_2340, 1'b0, 32'h0, 20, 1'b0, lat);
      check_output("paged_latency", 64'(lat), 64'd24);

      apply_stimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0000_2000, -1, 1'b0, lat);
      check_output("timeout_latency", 64'(lat), 64'(3 + TIMEOUT_CYCLES));
      #1;
      check_output("timeout_busy", 64'(o_busy), 64'd0);
      mmu_release = 1'b1;
      @(negedge clock); #1;
      mmu_release = 1'b0;

      // Abandon an access while the MMU is stuck in its wait phase.
      push_txn(1'b1, 3'd3, 32'h0000_7700, 1'b1, -1);
      @(negedge clock); #1;
      i_data_segment_index     = 3'd3;
      i_data_effective_address = 32'h0000_7700;
      i_data_write_enable      = 1'b1;
      i_data_request           = 1'b1;
      repeat (10) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_output("async_reset_control", 64'({o_fetch_done, o_data_done, o_fault, o_busy, o_mmu_vaild, o_mmu_write_enable}), 64'd0);
      check_output("async_reset_physical_address", 64'(o_physical_address), 64'd0);
      check_output("async_reset_mmu_operands", 64'({o_mmu_segment_index, o_mmu_effective_address}), 64'd0);
      op_q.delete();
      done_q.delete();
      model_pa = '0;
      starve_model = 0;
      i_data_request = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check_output("post_reset_idle", 64'({o_busy, o_data_done, o_fetch_done}), 64'd0);
      apply_stimulus(1'b0, 1'b1, 3'd1, 32'h0000_0ABC, 1'b0, 32'h0, 0, 1'b0, lat);
      check_output("post_reset_latency", 64'(lat), 64'd4);

      for (int i = 0; i < 25; i++) begin
         int kind, delay;
         kind  = $urandom_range(0, 2);
         delay = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
         apply_stimulus(kind != 0, kind != 1, 3'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)),
                        $urandom, delay, 1'b0, lat);
         if (kind != 2) check_output("random_latency", 64'(lat), 64'(4 + delay));
      end

      repeat (4) @(negedge clock);
      check_output("scoreboard_empty", 64'(done_q.size() + op_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_watchdog: simulation still running at cycle %0d, required completion", cycle);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
